// File: rtl/pingpong_pkg.sv
// Shared defaults and read-FSM encoding for the ping-pong buffer controller.
// Imported by the controller top and its address counters.
package pingpong_pkg;

    localparam int PP_ADDR_W = 4;
    localparam int PP_DEPTH  = 1 << PP_ADDR_W;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    // True when a counter value is the final word of a bank.
    function automatic logic at_last(
        input logic [PP_ADDR_W-1:0] v
    );
        return v == PP_ADDR_W'(PP_DEPTH - 1);
    endfunction

endpackage

// File: rtl/pp_addr_cnt.sv
// Bank address counter: synchronous clear, count enable,
// wrap after MAX and a combinational terminal-count flag.
module pp_addr_cnt
    import pingpong_pkg::*;
#(
    parameter int ADDR_W = PP_ADDR_W,
    parameter int MAX    = PP_DEPTH - 1
) (
    input  logic              clock_in,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] TC_VAL = ADDR_W'(MAX);

    assign tc = (cnt == TC_VAL);

    // Clear wins over enable; the count wraps to zero past MAX.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pingpong_ctrl.sv
// Ping-pong bank controller: fills one bank from the producer while
// the other is burst-read, swapping roles once a full bank is idle.
module pingpong_ctrl
    import pingpong_pkg::*;
#(
    parameter int DEPTH  = PP_DEPTH,
    parameter int ADDR_W = PP_ADDR_W
) (
    input  logic              clock_in,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_we,
    output logic [ADDR_W-1:0] w_add,
    output logic [ADDR_W-1:0] r_add,
    output logic              swich_ctrl,
    output logic              rd_en,
    output logic              out_valid,
    output logic              out_last,
    output logic              swap
);

    rd_state_t state;
    logic      wr_full;
    logic      swap_go;
    logic      w_tc;
    logic      r_tc;
    logic      burst;

    assign burst    = (state == RD_BURST);
    assign swap_go  = wr_full && (state == RD_IDLE);
    assign in_ready = !wr_full;
    assign wr_we    = in_valid && !wr_full && rst_n;
    assign rd_en    = burst;

    pp_addr_cnt #(
        .ADDR_W (ADDR_W),
        .MAX    (DEPTH - 1)
    ) u_wr_cnt (
        .clock_in (clock_in),
        .rst_n    (rst_n),
        .clr      (swap_go),
        .en       (wr_we),
        .cnt      (w_add),
        .tc       (w_tc)
    );

    pp_addr_cnt #(
        .ADDR_W (ADDR_W),
        .MAX    (DEPTH - 1)
    ) u_rd_cnt (
        .clock_in (clock_in),
        .rst_n    (rst_n),
        .clr      (swap_go),
        .en       (burst),
        .cnt      (r_add),
        .tc       (r_tc)
    );

    // Write bank is full after its last word until the swap frees it.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_full <= 1'b0;
        end else if (swap_go) begin
            wr_full <= 1'b0;
        end else if (wr_we && w_tc) begin
            wr_full <= 1'b1;
        end
    end

    // Read FSM with bank select and swap pulse; swap only from idle.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RD_IDLE;
            swich_ctrl <= 1'b1;
            swap       <= 1'b0;
        end else begin
            swap <= 1'b0;
            unique case (state)
                RD_IDLE: begin
                    if (swap_go) begin
                        state      <= RD_BURST;
                        swich_ctrl <= !swich_ctrl;
                        swap       <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (r_tc) begin
                        state <= RD_IDLE;
                    end
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

    // Read data qualifiers trail the issued read by the RAM latency.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= burst;
            out_last  <= burst && r_tc;
        end
    end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Bench for pingpong_ctrl: bank-level model plus RAM scoreboard,
// and directed sequences with literal expectations.
module tb_pingpong_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              wr_we;
    logic [ADDR_W-1:0] w_add;
    logic [ADDR_W-1:0] r_add;
    logic              swich_ctrl;
    logic              rd_en;
    logic              out_valid;
    logic              out_last;
    logic              swap;

    int checks = 0;
    int errors = 0;

    pingpong_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock_in   (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_we      (wr_we),
        .w_add      (w_add),
        .r_add      (r_add),
        .swich_ctrl (swich_ctrl),
        .rd_en      (rd_en),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .swap       (swap)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     name, act, exp, $time);
        end
    endfunction

    // Bank-level model: words in write bank, read progress, bank owner.
    int fill;
    int rd_idx;
    bit reading;
    bit wa;
    bit swp;
    bit pv;
    bit pl;

    // RAM scoreboard holding sequence numbers; -1 means empty/consumed.
    int mem [2][DEPTH];
    int wseq;
    int rseq;
    int rd_pipe;

    task automatic model_reset();
        fill    = 0;
        rd_idx  = 0;
        reading = 0;
        wa      = 1;
        swp     = 0;
        pv      = 0;
        pl      = 0;
        wseq    = 0;
        rseq    = 0;
        rd_pipe = -1;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[b][a] = -1;
            end
        end
    endtask

    always @(negedge clk) begin
        bit nv;
        bit nl;
        int wb;
        int rb;
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_wr_we", wr_we, 0);
            chk("rst_w_add", w_add, 0);
            chk("rst_r_add", r_add, 0);
            chk("rst_sw", swich_ctrl, 1);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_swap", swap, 0);
            model_reset();
        end else begin
            chk("m_in_ready", in_ready, int'(fill < DEPTH));
            chk("m_wr_we", wr_we, int'(in_valid && fill < DEPTH));
            chk("m_w_add", w_add, fill % DEPTH);
            chk("m_r_add", r_add, rd_idx);
            chk("m_rd_en", rd_en, int'(reading));
            chk("m_sw", swich_ctrl, int'(wa));
            chk("m_swap", swap, int'(swp));
            chk("m_out_valid", out_valid, int'(pv));
            chk("m_out_last", out_last, int'(pl));
            if (out_valid) begin
                chk("sb_order", rd_pipe, rseq);
                rseq++;
            end
            if (rd_en) begin
                rb = swich_ctrl ? 1 : 0;
                rd_pipe = mem[rb][r_add];
                chk("sb_unwritten", int'(rd_pipe >= 0), 1);
                mem[rb][r_add] = -1;
            end
            if (wr_we) begin
                wb = swich_ctrl ? 0 : 1;
                chk("sb_overwrite", int'(mem[wb][w_add] == -1), 1);
                mem[wb][w_add] = wseq;
                wseq++;
            end
            nv = reading;
            nl = reading && rd_idx == DEPTH - 1;
            if (fill == DEPTH && !reading) begin
                wa      = !wa;
                fill    = 0;
                reading = 1;
                rd_idx  = 0;
                swp     = 1;
            end else begin
                swp = 0;
                if (in_valid && fill < DEPTH) fill++;
                if (reading) begin
                    rd_idx++;
                    if (rd_idx == DEPTH) begin
                        reading = 0;
                        rd_idx  = 0;
                    end
                end
            end
            pv = nv;
            pl = nl;
        end
    end

    initial begin
        int cyc;
        int last;
        int nsw;
        bit prev_sw;
        bit found;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Fill bank A from reset with in_valid held.
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("fill_wr_we", wr_we, 1);
            chk("fill_w_add", w_add, i);
            chk("fill_sw", swich_ctrl, 1);
            chk("fill_swap", swap, 0);
        end
        @(negedge clk);
        chk("gap_in_ready", in_ready, 0);
        chk("gap_swap", swap, 0);

        // First burst out of bank A.
        for (int j = 0; j < DEPTH; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("swap1_pulse", swap, 1);
                chk("swap1_sw", swich_ctrl, 0);
                chk("swap1_w_add", w_add, 0);
            end
            chk("burst_rd_en", rd_en, 1);
            chk("burst_r_add", r_add, j);
            chk("burst_ov", out_valid, int'(j != 0));
            chk("burst_ol", out_last, 0);
        end
        @(negedge clk);
        chk("tail_ov", out_valid, 1);
        chk("tail_ol", out_last, 1);
        chk("tail_rd_en", rd_en, 0);

        // Sustained traffic: swap period and alternation.
        cyc     = 16;
        last    = 0;
        nsw     = 0;
        prev_sw = 1'b0;
        for (int k = 0; k < 68; k++) begin
            @(negedge clk);
            cyc++;
            if (swap) begin
                chk("swap_period", cyc - last, 17);
                chk("swap_alt", swich_ctrl, int'(!prev_sw));
                prev_sw = swich_ctrl;
                last    = cyc;
                nsw++;
            end
        end
        chk("swap_count", nsw, 4);

        // Producer stall after 10 words.
        @(posedge clk);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("stall_w_add", w_add, 10);
            chk("stall_swap", swap, 0);
            chk("stall_rd_en", rd_en, 0);
            chk("stall_wr_we", wr_we, 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("resume_wr_we", wr_we, 1);
            chk("resume_w_add", w_add, 10 + k);
            chk("resume_swap", swap, 0);
        end
        @(negedge clk);
        chk("resume_gap", in_ready, 0);
        @(negedge clk);
        chk("resume_swap1", swap, 1);
        chk("resume_sw", swich_ctrl, 0);

        // Reset in the middle of a burst at r_add 7.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (rd_en && r_add == 7) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_r_add7", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_ol", out_last, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_r_add", r_add, 0);
        chk("mid_rst_w_add", w_add, 0);
        chk("mid_rst_sw", swich_ctrl, 1);
        chk("mid_rst_swap", swap, 0);
        chk("mid_rst_wr_we", wr_we, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_w_add", w_add, 0);
        chk("post_rst_wr_we", wr_we, 1);
        chk("post_rst_sw", swich_ctrl, 1);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk("post_rst_ov", out_valid, 0);
        end
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
